ram_arbiter: RTL
================

Name: ram_arbiter

Overview:
Clocked controller that sequences the asynchronous 4Kx4 RAM (12-bit address, chip select, write enable, bidirectional 4-bit data) and shares it between two requesters. Each requester issues single-word read or write transactions over a req/ack handshake. The arbiter generates the RAM strobes with setup, access and recovery phases and owns the tri-state data bus. It sits between the RAM and its users, e.g. a program loader and a CPU fetch/data path.

Parameters:
ADDR_W, 12, RAM address width.
DATA_W, 4, RAM data width.
ACCESS_CYCLES, 2, cycles cs is held active per access; legal range 1..15.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
req0  input  1  requester 0 transaction request.
we0  input  1  requester 0 direction: 1 = write, 0 = read.
addr0  input  ADDR_W  requester 0 address.
wdata0  input  DATA_W  requester 0 write data.
ack0  output  1  requester 0 completion pulse.
rdata0  output  DATA_W  requester 0 read data.
req1, we1, addr1, wdata1, ack1, rdata1: same as port 0, for requester 1.
ram_addr  output  ADDR_W  RAM address.
ram_cs  output  1  RAM chip select.
ram_we  output  1  RAM write enable.
ram_data  inout  DATA_W  RAM data bus.
busy  output  1  high whenever FSM is not IDLE.

Behaviour:
- Reset (async, reset_n=0): ram_cs=0, ram_we=0, ram_addr=0, ram_data released (z), ack0=ack1=0, rdata0=rdata1=0, busy=0, FSM=IDLE, round-robin pointer favours requester 0. All outputs are registered.
- FSM: IDLE -> SETUP -> ACCESS -> RECOVER -> IDLE.
- IDLE: at the edge where any req is high, pick a winner, capture its we/addr/wdata into internal registers, and go to SETUP. Requester inputs are ignored after capture.
- SETUP (1 cycle): ram_addr = captured address; ram_cs=0, ram_we=0. For writes, the bus is driven with the captured wdata.
- ACCESS (ACCESS_CYCLES cycles, counted by an internal down-counter): ram_cs=1, and ram_we = captured we. For writes, the bus stays driven. For reads, the bus is released and ram_data is sampled into the winner's rdata at the edge leaving ACCESS.
- RECOVER (1 cycle): ram_cs=0, ram_we=0, address held. For writes, the bus stays driven this cycle (data hold) and is released on entry to IDLE. The winner's ack is high for exactly this cycle.
- Latency: req sampled at edge k -> ack high in cycle k+ACCESS_CYCLES+2. Back-to-back throughput is one access per ACCESS_CYCLES+3 cycles, because IDLE always lasts at least one cycle.
- Handshake: req, we, addr and wdata must be stable until grant capture. ack is a 1-cycle pulse. rdata is valid from the ack cycle and held until the next read completes on that port. Writes do not alter rdata. If req is still high in the cycle after ack, it is a new request.
- Arbitration (see Optional Feature): when both reqs are high at IDLE, the favoured requester wins and the pointer then favours the other one. A single requester always wins regardless of the pointer.
- Bus safety: the bus drive enable is never high while ram_cs=1 and ram_we=0. Drive is only asserted in SETUP/ACCESS/RECOVER of write transactions. The bus is always z in IDLE.
- Reset mid-transaction: strobes drop and the bus is released immediately (asynchronously), with no ack. The interrupted write may be partial; no retry.
- ram_we is never high while ram_cs is low.
- ram_addr is held at its last value in IDLE.

Optional Feature:
RAM_ARB_RR_EN: when defined, arbitration is round-robin as described above. When undefined, the scheme is fixed priority: requester 0 always wins ties, the round-robin pointer logic is removed, and requester 1 is served only when req0 is low at IDLE.

Test Plan:
- Port0 write addr=0x0A5, data=0x9, then port0 read 0x0A5 -> ack0 at cycle k+4 each (ACCESS_CYCLES=2); rdata0=0x9; ram_we high for exactly 2 cycles during the write.
- req0 and req1 both held high: reads of 0x001 and 0x002 pre-loaded with 0x3 and 0xC -> with RAM_ARB_RR_EN, acks alternate 0,1,0,1 with rdata0=0x3 and rdata1=0xC; without the macro, only ack0 fires.
- Port1 writes 0xFFF=0x5, then port0 writes 0x000=0xA, then both read back -> values correct, confirming the address extremes carry no wrap.
- reset_n pulled low during ACCESS of a write -> ram_cs, ram_we and bus drive drop without waiting for a clock edge; no ack; busy=0; the next request completes normally.
- Continuous assertion check over random traffic: never (ram_cs && !ram_we && drive enable); never (ram_we && !ram_cs); ack0 and ack1 never high together.
- ACCESS_CYCLES=1: write then read -> ack 3 cycles after req; data correct.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-requester sequencer for an async RAM; RAM_ARB_RR_EN selects round-robin ties, else requester 0 has priority.
// Latency: req sampled at edge k gives ack in cycle k+ACCESS_CYCLES+2; one access per ACCESS_CYCLES+3 cycles.
// Backpressure: a requester holds req/we/addr/wdata until granted; it is stalled simply by not being granted.
module ram_arbiter #(
    parameter int ADDR_W        = 12,
    parameter int DATA_W        = 4,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_cs,
    output logic              ram_we,
    inout  wire  [DATA_W-1:0] ram_data,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RECOVER} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              we_q;
    logic              sel_q;
    logic [DATA_W-1:0] wdata_q;
    logic              bus_drive;
    logic              grant1;

`ifdef RAM_ARB_RR_EN
    logic ptr;
    assign grant1 = req1 && (!req0 || ptr);
`else
    assign grant1 = req1 && !req0;
`endif

    // Drive is a flop cleared by reset, so the bus releases asynchronously.
    assign ram_data = bus_drive ? wdata_q : {DATA_W{1'bz}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            sel_q     <= 1'b0;
            wdata_q   <= '0;
            bus_drive <= 1'b0;
            ram_addr  <= '0;
            ram_cs    <= 1'b0;
            ram_we    <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            busy      <= 1'b0;
`ifdef RAM_ARB_RR_EN
            ptr       <= 1'b0;
`endif
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        sel_q     <= grant1;
                        we_q      <= grant1 ? we1 : we0;
                        wdata_q   <= grant1 ? wdata1 : wdata0;
                        ram_addr  <= grant1 ? addr1 : addr0;
                        bus_drive <= grant1 ? we1 : we0;
                        busy      <= 1'b1;
                        state     <= SETUP;
`ifdef RAM_ARB_RR_EN
                        if (req0 && req1)
                            ptr <= !ptr;
`endif
                    end
                end
                SETUP: begin
                    ram_cs <= 1'b1;
                    ram_we <= we_q;
                    cnt    <= 4'(ACCESS_CYCLES - 1);
                    state  <= ACCESS;
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        ram_cs <= 1'b0;
                        ram_we <= 1'b0;
                        state  <= RECOVER;
                        if (sel_q)
                            ack1 <= 1'b1;
                        else
                            ack0 <= 1'b1;
                        if (!we_q) begin
                            if (sel_q)
                                rdata1 <= ram_data;
                            else
                                rdata0 <= ram_data;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RECOVER: begin
                    // Write data is held through this cycle, released on entry to IDLE.
                    bus_drive <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
